// File: rtl/avrpp_pkg.sv
// Shared definitions for the AVR high-voltage parallel-programming sequencer:
// operation codes, FSM state encoding and the XA/BS/data-drive level table.
package avrpp_pkg;

    localparam logic [2:0] OP_LD_CMD = 3'd0;
    localparam logic [2:0] OP_LD_ALO = 3'd1;
    localparam logic [2:0] OP_LD_AHI = 3'd2;
    localparam logic [2:0] OP_LD_DLO = 3'd3;
    localparam logic [2:0] OP_LD_DHI = 3'd4;
    localparam logic [2:0] OP_PAGEL  = 3'd5;
    localparam logic [2:0] OP_PROG   = 3'd6;
    localparam logic [2:0] OP_READ   = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_PULSE    = 3'd2,
        ST_HOLD     = 3'd3,
        ST_WAIT_RDY = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

    // Levels held from SETUP through HOLD.
    typedef struct packed {
        logic xa1;
        logic xa0;
        logic bs1;
        logic bs2;
        logic doe;
    } levels_t;

    // Level table per operation; PROG and READ take BS1/BS2 from data bits 0/1.
    function automatic levels_t op_levels(input logic [2:0] op, input logic [1:0] bs);
        levels_t lv;
        lv = '0;
        case (op)
            OP_LD_CMD: begin lv.xa1 = 1'b1; lv.doe = 1'b1; end
            OP_LD_ALO: begin lv.doe = 1'b1; end
            OP_LD_AHI: begin lv.bs1 = 1'b1; lv.doe = 1'b1; end
            OP_LD_DLO: begin lv.xa0 = 1'b1; lv.doe = 1'b1; end
            OP_LD_DHI: begin lv.xa0 = 1'b1; lv.bs1 = 1'b1; lv.doe = 1'b1; end
            OP_PAGEL:  begin lv.bs1 = 1'b1; end
            default:   begin lv.bs1 = bs[0]; lv.bs2 = bs[1]; end
        endcase
        return lv;
    endfunction

endpackage

// File: rtl/avrpp_rdy_sync.sv
// Two-flop synchroniser for the asynchronous DUT RDY/BSY pin.
// Resets to 1 so a freshly reset sequencer sees the DUT as ready.
module avrpp_rdy_sync (
    input  logic osc_in,
    input  logic rst_n,
    input  logic rdy_async,
    output logic rdy_sync
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Next values: shift the pin through two stages.
    always_comb begin
        meta_d = rdy_async;
        sync_d = meta_q;
    end

    // Synchroniser flops.
    always_ff @(posedge osc_in or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign rdy_sync = sync_q;

endmodule

// File: rtl/avrpp_cmd_seq.sv
// AVR HVPP command sequencer: runs one host operation as
// SETUP -> PULSE -> HOLD -> [WAIT_RDY for PROG] -> DONE.
// Optional build macro AVRPP_RDY_TIMEOUT_EN bounds WAIT_RDY to RDY_TMO cycles
// and reports the expiry through rsp_err; without it rsp_err is tied 0.
// Handshake: an operation is accepted on a rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high only in IDLE and rsp_valid is a
// one-cycle completion pulse.
module avrpp_cmd_seq
    import avrpp_pkg::*;
#(
    parameter int T_SETUP = 2,
    parameter int T_PULSE = 4,
    parameter int T_HOLD  = 2,
    parameter int RDY_TMO = 24000
) (
    input  logic       osc_in,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    input  logic       dut_rdy,
    input  logic [7:0] dut_din,
    output logic [7:0] dut_dout,
    output logic       dut_doe,
    output logic       dut_xa0,
    output logic       dut_xa1,
    output logic       dut_bs1,
    output logic       dut_bs2,
    output logic       dut_xtal,
    output logic       dut_pagel,
    output logic       dut_wr_n,
    output logic       dut_oe_n
);

    localparam int T_MAX_A = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
    localparam int T_MAX_B = (T_HOLD > RDY_TMO) ? T_HOLD : RDY_TMO;
    localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int CNT_W   = $clog2(T_MAX) + 1;

    localparam logic [CNT_W-1:0] C_SETUP = CNT_W'(T_SETUP);
    localparam logic [CNT_W-1:0] C_PULSE = CNT_W'(T_PULSE);
    localparam logic [CNT_W-1:0] C_HOLD  = CNT_W'(T_HOLD);
    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

    // A zero-length phase would make the counter wrap; refuse to elaborate.
    if (T_SETUP < 1 || T_PULSE < 1 || T_HOLD < 1 || RDY_TMO < 1) begin : g_param_check
        $error("avrpp_cmd_seq: T_SETUP, T_PULSE, T_HOLD and RDY_TMO must be >= 1");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [7:0]       data_q, data_d;
    logic [7:0]       rsp_data_q, rsp_data_d;
    logic             rdy_s;
    logic             cnt_last;
    levels_t          lv;

`ifdef AVRPP_RDY_TIMEOUT_EN
    localparam logic [CNT_W-1:0] C_TMO = CNT_W'(RDY_TMO);
    logic err_q, err_d;
`endif

    avrpp_rdy_sync u_rdy_sync (
        .osc_in    (osc_in),
        .rst_n     (rst_n),
        .rdy_async (dut_rdy),
        .rdy_sync  (rdy_s)
    );

    assign cnt_last = (cnt_q == C_ONE);

    // State register plus latched operation, phase counter and read result.
    always_ff @(posedge osc_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            op_q       <= OP_LD_CMD;
            data_q     <= 8'h00;
            rsp_data_q <= 8'h00;
`ifdef AVRPP_RDY_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            data_q     <= data_d;
            rsp_data_q <= rsp_data_d;
`ifdef AVRPP_RDY_TIMEOUT_EN
            err_q      <= err_d;
`endif
        end
    end

    // Next state: each phase reloads the counter on entry and leaves on its last cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        data_d     = data_q;
        rsp_data_d = rsp_data_q;
`ifdef AVRPP_RDY_TIMEOUT_EN
        err_d      = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_d = ST_SETUP;
                    cnt_d   = C_SETUP;
                    op_d    = cmd_op;
                    data_d  = cmd_data;
`ifdef AVRPP_RDY_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            ST_SETUP: begin
                if (cnt_last) begin
                    state_d = ST_PULSE;
                    cnt_d   = C_PULSE;
                end else begin
                    cnt_d = cnt_q - C_ONE;
                end
            end
            ST_PULSE: begin
                // The bus is sampled at the end of the OE-low window.
                if (cnt_last && op_q == OP_READ) begin
                    rsp_data_d = dut_din;
                end
                if (cnt_last) begin
                    state_d = ST_HOLD;
                    cnt_d   = C_HOLD;
                end else begin
                    cnt_d = cnt_q - C_ONE;
                end
            end
            ST_HOLD: begin
                if (cnt_last) begin
                    if (op_q == OP_PROG) begin
                        state_d = ST_WAIT_RDY;
`ifdef AVRPP_RDY_TIMEOUT_EN
                        cnt_d   = C_TMO;
`endif
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    cnt_d = cnt_q - C_ONE;
                end
            end
            ST_WAIT_RDY: begin
                if (rdy_s) begin
                    state_d = ST_DONE;
                end
`ifdef AVRPP_RDY_TIMEOUT_EN
                else if (cnt_last) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - C_ONE;
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs: levels during SETUP..HOLD, strobe only during PULSE, idle levels otherwise.
    always_comb begin
        lv        = op_levels(op_q, data_q[1:0]);
        cmd_ready = (state_q == ST_IDLE);
        rsp_valid = (state_q == ST_DONE);
        dut_dout  = 8'h00;
        dut_doe   = 1'b0;
        dut_xa0   = 1'b0;
        dut_xa1   = 1'b0;
        dut_bs1   = 1'b0;
        dut_bs2   = 1'b0;
        dut_xtal  = 1'b0;
        dut_pagel = 1'b0;
        dut_wr_n  = 1'b1;
        dut_oe_n  = 1'b1;
        if (state_q == ST_SETUP || state_q == ST_PULSE || state_q == ST_HOLD) begin
            dut_xa0  = lv.xa0;
            dut_xa1  = lv.xa1;
            dut_bs1  = lv.bs1;
            dut_bs2  = lv.bs2;
            dut_doe  = lv.doe;
            dut_dout = lv.doe ? data_q : 8'h00;
        end
        if (state_q == ST_PULSE) begin
            case (op_q)
                OP_PAGEL: dut_pagel = 1'b1;
                OP_PROG:  dut_wr_n  = 1'b0;
                OP_READ:  dut_oe_n  = 1'b0;
                default:  dut_xtal  = 1'b1;
            endcase
        end
    end

    assign rsp_data = rsp_data_q;

`ifdef AVRPP_RDY_TIMEOUT_EN
    assign rsp_err = (state_q == ST_DONE) && err_q;
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_avrpp_cmd_seq.sv
// Bench for avrpp_cmd_seq: directed operations, a cycle-indexed reference
// model compared on every falling edge, and literal timing expectations.
module tb_avrpp_cmd_seq;

    localparam int S   = 2;
    localparam int P   = 4;
    localparam int H   = 2;
    localparam int TMO = 100;

    logic       osc_in = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_op = 3'd0;
    logic [7:0] cmd_data = 8'h00;
    logic [7:0] dut_din = 8'h00;
    logic       dut_rdy = 1'b1;
    logic       cmd_ready, rsp_valid, rsp_err;
    logic [7:0] rsp_data, dut_dout;
    logic       dut_doe, dut_xa0, dut_xa1, dut_bs1, dut_bs2;
    logic       dut_xtal, dut_pagel, dut_wr_n, dut_oe_n;

    int checks = 0;
    int errors = 0;

    avrpp_cmd_seq #(.T_SETUP(S), .T_PULSE(P), .T_HOLD(H), .RDY_TMO(TMO)) dut (
        .osc_in    (osc_in),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .dut_rdy   (dut_rdy),
        .dut_din   (dut_din),
        .dut_dout  (dut_dout),
        .dut_doe   (dut_doe),
        .dut_xa0   (dut_xa0),
        .dut_xa1   (dut_xa1),
        .dut_bs1   (dut_bs1),
        .dut_bs2   (dut_bs2),
        .dut_xtal  (dut_xtal),
        .dut_pagel (dut_pagel),
        .dut_wr_n  (dut_wr_n),
        .dut_oe_n  (dut_oe_n)
    );

    // ---------------- clock ----------------
    always #5 osc_in = ~osc_in;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // m_k counts cycles since acceptance (1 = first SETUP cycle).
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    logic       m_err = 1'b0;
    int         m_k = 0;
    int         m_kp;
    logic [2:0] m_op = 3'd0;
    logic [7:0] m_data = 8'h00;
    logic [7:0] m_rsp_data = 8'h00;
    logic       m_s1 = 1'b1;
    logic       m_s2 = 1'b1;
    logic       m_vis;

    always @(posedge osc_in or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_k = 0;
            m_rsp_data = 8'h00; m_s1 = 1'b1; m_s2 = 1'b1;
        end else begin
            m_vis = m_s2;
            m_s2  = m_s1;
            m_s1  = dut_rdy;
            if (m_busy) begin
                if (m_done) begin
                    m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
                end else begin
                    m_kp = m_k;
                    m_k  = m_kp + 1;
                    if (m_op == 3'd7 && m_kp == S + P) m_rsp_data = dut_din;
                    if (m_op != 3'd6) begin
                        m_done = (m_k == S + P + H + 1);
                    end else if (m_kp > S + P + H) begin
                        if (m_vis) m_done = 1'b1;
`ifdef AVRPP_RDY_TIMEOUT_EN
                        else if (m_kp - (S + P + H) == TMO) begin
                            m_done = 1'b1; m_err = 1'b1;
                        end
`endif
                    end
                end
            end else if (cmd_valid) begin
                m_busy = 1'b1; m_k = 1; m_op = cmd_op; m_data = cmd_data;
            end
        end
    end

    // {xa1, xa0, bs1, bs2, doe} for each operation.
    function automatic logic [4:0] tb_levels(input logic [2:0] op, input logic [7:0] d);
        case (op)
            3'd0:    return 5'b10001;
            3'd1:    return 5'b00001;
            3'd2:    return 5'b00101;
            3'd3:    return 5'b01001;
            3'd4:    return 5'b01101;
            3'd5:    return 5'b00100;
            default: return {2'b00, d[0], d[1], 1'b0};
        endcase
    endfunction

    logic [4:0]  c_lv;
    logic [16:0] c_exp, c_act;
    logic        c_stb;

    // Compare process: every falling edge out of reset.
    always @(negedge osc_in) begin
        if (rst_n) begin
            c_exp = {1'b0, 8'h00, 6'b000000, 2'b11};
            if (m_busy && !m_done && m_k <= S + P + H) begin
                c_lv  = tb_levels(m_op, m_data);
                c_stb = (m_k > S) && (m_k <= S + P);
                c_exp = {c_lv[0], (c_lv[0] ? m_data : 8'h00), c_lv[3], c_lv[4], c_lv[2], c_lv[1],
                         c_stb && m_op <= 3'd4, c_stb && m_op == 3'd5,
                         !(c_stb && m_op == 3'd6), !(c_stb && m_op == 3'd7)};
            end
            c_act = {dut_doe, dut_dout, dut_xa0, dut_xa1, dut_bs1, dut_bs2,
                     dut_xtal, dut_pagel, dut_wr_n, dut_oe_n};
            check("pins", c_act, c_exp);
            check("handshake", {cmd_ready, rsp_valid, rsp_err}, {!m_busy, m_done, m_done && m_err});
            check("rsp_data", rsp_data, m_rsp_data);
        end
    end

    // ---------------- driver ----------------
    // Cycle 0 is the cycle whose rising edge accepts the operation.
    task automatic do_op(input logic [2:0] op, input logic [7:0] data, input logic [7:0] din,
                         input int rdy_rise, input int max_cyc,
                         output int rsp_c, output int first_stb, output int stb_n,
                         output logic err, output logic [12:0] snap);
        int n;
        rsp_c = -1; first_stb = -1; stb_n = 0; err = 1'b0; snap = '0;
        @(negedge osc_in);
        cmd_op = op; cmd_data = data; dut_din = din; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge osc_in);
            n++;
        end
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            @(negedge osc_in);
            if (cyc == 1) begin
                cmd_valid = 1'b0;
                snap = {dut_doe, dut_dout, dut_xa1, dut_xa0, dut_bs1, dut_bs2};
            end
            if (dut_xtal || dut_pagel || !dut_wr_n || !dut_oe_n) begin
                if (first_stb < 0) first_stb = cyc;
                stb_n++;
            end
            if (rsp_valid) begin
                rsp_c = cyc;
                err = rsp_err;
                break;
            end
            if (cyc == rdy_rise) dut_rdy = 1'b1;
        end
        if (rsp_c < 0) check("op_timeout", 32'd1, 32'd0);
    endtask

    int          r_c, r_first, r_n;
    logic        r_err;
    logic [12:0] r_snap;
    int          acc, rsp1, acc2, rsp_cnt;
    logic [2:0]  tbl_op[5]   = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    logic [7:0]  tbl_data[5] = '{8'h3C, 8'h81, 8'hFF, 8'h00, 8'h7E};

    initial begin
        repeat (3) @(negedge osc_in);
        rst_n = 1'b1;
        @(negedge osc_in);
        check("reset_idle", {cmd_ready, rsp_valid, rsp_err, dut_doe, dut_wr_n, dut_oe_n, dut_xtal},
              {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
        check("reset_rsp_data", rsp_data, 8'h00);

        // LD_CMD 0x10
        do_op(3'd0, 8'h10, 8'h00, 0, 200, r_c, r_first, r_n, r_err, r_snap);
        check("ldcmd_latency", r_c, 9);
        check("ldcmd_xtal_start", r_first, 3);
        check("ldcmd_xtal_len", r_n, 4);
        check("ldcmd_levels", r_snap, {1'b1, 8'h10, 4'b1000});

        // READ with BS1=1, bus shows 0xA5
        do_op(3'd7, 8'h01, 8'hA5, 0, 200, r_c, r_first, r_n, r_err, r_snap);
        check("read_latency", r_c, 9);
        check("read_oe_len", r_n, 4);
        check("read_levels", r_snap, {1'b0, 8'h00, 4'b0010});
        check("read_data", rsp_data, 8'hA5);

        // Remaining load operations and PAGEL
        for (int i = 0; i < 5; i++) begin
            do_op(tbl_op[i], tbl_data[i], 8'h00, 0, 200, r_c, r_first, r_n, r_err, r_snap);
            check("ld_latency", r_c, 9);
            check("ld_strobe_len", r_n, 4);
        end
        check("rsp_data_held", rsp_data, 8'hA5);

        // PROG with RDY already high: one WAIT_RDY cycle
        do_op(3'd6, 8'h02, 8'h00, 0, 200, r_c, r_first, r_n, r_err, r_snap);
        check("prog_fast_latency", r_c, 10);
        check("prog_wr_len", r_n, 4);

        // PROG with RDY low until cycle 50
        dut_rdy = 1'b0;
        do_op(3'd6, 8'h00, 8'h00, 50, 300, r_c, r_first, r_n, r_err, r_snap);
        check("prog_rdy_latency", r_c, 53);
        check("prog_rdy_err", r_err, 1'b0);

        // Second READ with another pattern
        do_op(3'd7, 8'h02, 8'h5A, 0, 200, r_c, r_first, r_n, r_err, r_snap);
        check("read2_data", rsp_data, 8'h5A);

`ifdef AVRPP_RDY_TIMEOUT_EN
        dut_rdy = 1'b0;
        do_op(3'd6, 8'h00, 8'h00, 0, 400, r_c, r_first, r_n, r_err, r_snap);
        check("tmo_latency", r_c, 9 + TMO);
        check("tmo_err", r_err, 1'b1);
        @(negedge osc_in);
        check("tmo_pins_idle", {dut_wr_n, dut_oe_n, dut_doe, cmd_ready}, 4'b1101);
        dut_rdy = 1'b1;
        repeat (3) @(negedge osc_in);
`endif

        // Reset during the PAGEL strobe
        @(negedge osc_in);
        cmd_op = 3'd5; cmd_data = 8'h00; cmd_valid = 1'b1;
        @(negedge osc_in);
        cmd_valid = 1'b0;
        for (int i = 0; i < 20 && !dut_pagel; i++) @(negedge osc_in);
        check("pagel_reached", dut_pagel, 1'b1);
        @(posedge osc_in);
        #2 rst_n = 1'b0;
        #1 check("async_reset_pins", {dut_pagel, dut_wr_n, dut_oe_n, dut_doe, rsp_valid},
                 {1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        @(negedge osc_in);
        rst_n = 1'b1;
        rsp_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge osc_in);
            if (rsp_valid) rsp_cnt++;
        end
        check("reset_no_rsp", rsp_cnt, 0);
        check("reset_ready", cmd_ready, 1'b1);

        // cmd_valid held across two operations
        @(negedge osc_in);
        cmd_op = 3'd1; cmd_data = 8'h55; cmd_valid = 1'b1;
        acc = 0; rsp1 = -1; acc2 = -1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc > 0) @(negedge osc_in);
            if (rsp_valid && rsp1 < 0) rsp1 = cyc;
            if (cmd_valid && cmd_ready) begin
                acc++;
                if (acc == 2) acc2 = cyc;
            end else if (acc == 2) begin
                cmd_valid = 1'b0;
            end
        end
        check("b2b_accepts", acc, 2);
        check("b2b_first_rsp", rsp1, 9);
        check("b2b_gap", acc2 - rsp1, 1);

        repeat (3) @(negedge osc_in);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
